// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: one shared period counter, N_CH duty comparators,
// edge/center alignment, double-buffered settings applied only at period boundaries.
module pwm_multi #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic                  load,
  input  logic [CNT_W-1:0]      period,
  input  logic [N_CH*CNT_W-1:0] duty,
  input  logic                  center_mode,
  input  logic [N_CH-1:0]       polarity,
  output logic [N_CH-1:0]       pwm_out,
  output logic                  period_start,
  output logic                  upd_pending
);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  logic [CNT_W-1:0]      period_a, period_s;
  logic [N_CH*CNT_W-1:0] duty_a, duty_s;
  logic                  mode_a, mode_s;
  logic                  pend;

  logic [CNT_W-1:0] cnt, cnt_nxt;
  dir_t             dir, dir_nxt;
  logic [CNT_W-1:0] p_eff, p_last;
  logic             last_cycle, upd;
  logic [N_CH-1:0]  raw;

  // A zero period behaves as one, so the counter always has a valid terminal value.
  assign p_eff  = (period_a == '0) ? CNT_W'(1) : period_a;
  assign p_last = p_eff - CNT_W'(1);

  assign last_cycle = mode_a ? ((dir == DIR_DOWN) && (cnt == '0))
                             : (cnt == p_last);
  assign upd        = !en || last_cycle;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt <= '0;
      dir <= DIR_UP;
    end else begin
      cnt <= cnt_nxt;
      dir <= dir_nxt;
    end
  end

  // In center mode the top value is held for a second cycle while the direction flips.
  always_comb begin
    cnt_nxt = cnt;
    dir_nxt = dir;
    if (upd) begin
      cnt_nxt = '0;
      dir_nxt = DIR_UP;
    end else if (mode_a) begin
      if (dir == DIR_UP) begin
        if (cnt == p_last) dir_nxt = DIR_DOWN;
        else               cnt_nxt = cnt + CNT_W'(1);
      end else begin
        cnt_nxt = cnt - CNT_W'(1);
      end
    end else begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  // A load landing on an update point bypasses the shadow and goes live directly.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      period_a <= '0;
      duty_a   <= '0;
      mode_a   <= 1'b0;
      period_s <= '0;
      duty_s   <= '0;
      mode_s   <= 1'b0;
      pend     <= 1'b0;
    end else begin
      if (load) begin
        period_s <= period;
        duty_s   <= duty;
        mode_s   <= center_mode;
      end
      if (upd) begin
        pend <= 1'b0;
        if (load) begin
          period_a <= period;
          duty_a   <= duty;
          mode_a   <= center_mode;
        end else if (pend) begin
          period_a <= period_s;
          duty_a   <= duty_s;
          mode_a   <= mode_s;
        end
      end else if (load) begin
        pend <= 1'b1;
      end
    end
  end

  always_comb begin
    raw = '0;
    for (int i = 0; i < N_CH; i++) begin
      raw[i] = (cnt < duty_a[i*CNT_W +: CNT_W]);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pwm_out      <= '0;
      period_start <= 1'b0;
    end else if (!en) begin
      pwm_out      <= polarity;
      period_start <= 1'b0;
    end else begin
      pwm_out      <= raw ^ polarity;
      period_start <= (cnt == '0) && (dir == DIR_UP);
    end
  end

  assign upd_pending = pend;

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Parametrised multi-channel PWM generator. One shared period counter drives `N_CH` independent duty comparators, with edge- or center-aligned mode and per-channel output polarity. All period, duty and mode settings are double-buffered and take effect only at a period boundary, so outputs never glitch. Sits between the control register file and the pad/driver logic.

## Interface
- `N_CH`, 4: number of PWM channels (1..32)
- `CNT_W`, 16: width of the counter, period and duty values (2..32)
- `clk` input 1: single clock; all logic on its rising edge
- `nrst` input 1: reset; asynchronous, active-low
- `en` input 1: run enable
- `load` input 1: one-cycle strobe; captures `period`, `duty`, `center_mode` into shadow
- `period` input CNT_W: period P in counter steps; 0 is treated as 1
- `duty` input N_CH*CNT_W: channel i duty D_i at bits [i*CNT_W +: CNT_W]
- `center_mode` input 1: 0 = edge-aligned, 1 = center-aligned
- `polarity` input N_CH: per channel, 1 inverts the output; applied live, not shadowed
- `pwm_out` output N_CH: registered PWM outputs
- `period_start` output 1: registered one-cycle pulse, aligned with the first `pwm_out` cycle of each period
- `upd_pending` output 1: shadow holds values not yet applied

## Operation
- Active set: `P_a`, `D_a[i]`, `M_a`. Shadow set: `P_s`, `D_s[i]`, `M_s`, plus `pend` flag.
- On `load`: shadow <= inputs, `pend` <= 1.
- Edge mode: `cnt` counts 0,1,…,P_a-1 then wraps to 0. Period = P_a cycles.
- Center mode: `cnt` counts up 0..P_a-1, then down P_a-1..0. Direction flag `dir` (0 = up). Period = 2*P_a cycles, and each value appears twice.
- Last cycle of a period:
  - edge mode: `cnt == P_a-1`
  - center mode: `dir == 1 && cnt == 0`
- Update point: the clock edge that ends the last cycle of a period, or any edge while `en == 0`. At an update point:
  - `cnt` <= 0 and `dir` <= 0.
  - If `load` is asserted in that same cycle, the active set takes the `load` inputs directly. Otherwise, if `pend` is set, the active set takes the shadow set. `pend` <= 0 in both cases.
- Channel compare: `raw[i] = (cnt < D_a[i])`.
  - `pwm_out[i]` <= `raw[i] ^ polarity[i]`.
  - High time per period is D_i cycles in edge mode and 2*D_i cycles in center mode.
  - D_i = 0 gives constant inactive. D_i >= P_a gives constant active.
- Center mode with P_a = 1: `cnt` stays 0 and each period is 2 cycles.
- `en == 0`:
  - `cnt` is held at 0 and `dir` at 0.
  - `pwm_out` <= `polarity`, i.e. inactive level.
  - `period_start` <= 0.
  - Any `load` is applied to the active set at the next edge.
- `en` rising: the first period begins with `cnt = 0` on the first enabled cycle.
- Counter arithmetic is CNT_W-bit unsigned. Comparisons use the active P_a after the 0→1 substitution. `cnt` never exceeds P_a-1.

## Timing
- Async reset (`nrst` low), applied immediately regardless of `clk`:
  - `cnt` = 0, `dir` = 0
  - active and shadow sets = 0, `pend` = 0
  - `pwm_out` = 0, `period_start` = 0, `upd_pending` = 0
- Reset release: the first clock edge after release behaves per `en`.
- Output latency: `pwm_out` at edge t+1 reflects `cnt` and `D_a` at cycle t (1 cycle).
- `period_start` is asserted on the edge after the cycle with `cnt == 0` and `dir == 0` while `en == 1` (first up-count cycle in center mode).
- `upd_pending` = `pend`. It rises the cycle after `load` and falls the cycle after the update point.
- `load` held for several cycles: last captured value wins. New values are never visible mid-period.
- Reset asserted mid-period: outputs go to 0 immediately. No partial period resumes after release.

## Test plan
- N_CH=2, CNT_W=8, edge mode, P=10, D0=3, D1=0, pol=00, en=1:
  - `pwm_out[0]` high 3 of every 10 cycles; `pwm_out[1]` constant 0.
  - `period_start` every 10 cycles, coincident with the rising `pwm_out[0]`.
- Center mode, P=4, D0=1:
  - `cnt` sequence 0,1,2,3,3,2,1,0.
  - `pwm_out[0]` high 2 consecutive cycles per 8-cycle period, spanning the period wrap.
- Shadow update: running P=10, D0=3; `load` with D0=7 at `cnt` = 4:
  - remainder of current period still uses 3 cycles high;
  - next period uses 7 high;
  - `upd_pending` high from the cycle after `load` until the cycle after the wrap.
- Limits:
  - D0=10 with P=10 → constant high, `period_start` still pulsing.
  - D1=0 with pol[1]=1 → constant high.
  - P=0 → treated as P=1.
  - `load` coincident with the wrap edge → applied in the new period.
- Control and reset:
  - Drop `en` mid-period → next cycle `pwm_out` = polarity and `cnt` = 0.
  - Re-enable → full first period.
  - Assert `nrst` mid-period → `pwm_out` = 0 with no clock edge.
  - After release with en=1 and no `load` → outputs stay inactive (D_a = 0).
